// File: rtl/edge_morph_filter_pkg.sv
// Shared definitions for the Sobel post-processing edge/morphology stage.
// H_ACTIVE_DEF is the line length shared with the upstream Sobel stage.
package edge_morph_filter_pkg;

    localparam int         H_ACTIVE_DEF = 1280;
    localparam logic [7:0] THRESH_DEF   = 8'd200;
    localparam logic [7:0] EDGE_VAL_DEF = 8'h00;
    localparam logic [7:0] BG_VAL_DEF   = 8'hFF;

    typedef enum logic [1:0] {
        MODE_BIN = 2'd0,
        MODE_DIL = 2'd1,
        MODE_ERO = 2'd2,
        MODE_RAW = 2'd3
    } mode_e;

    function automatic logic [7:0] pix_map(input logic       is_edge,
                                           input logic [7:0] edge_val,
                                           input logic [7:0] bg_val);
        return is_edge ? edge_val : bg_val;
    endfunction

endpackage

// File: rtl/morph_line_ram.sv
// Single-port line buffer: combinational read, synchronous write, so a read
// and a write to the same address in one cycle return the old contents.
module morph_line_ram #(
    parameter  int DEPTH = 1280,
    parameter  int WIDTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/edge_morph_filter.sv
// Thresholds Sobel grey output to a binary edge map and applies a selectable
// 3x3 dilate/erode over a trailing (non-centred) window; fixed 2-cycle latency.
module edge_morph_filter
    import edge_morph_filter_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter logic [7:0] THRESH   = THRESH_DEF,
    parameter logic [7:0] EDGE_VAL = EDGE_VAL_DEF,
    parameter logic [7:0] BG_VAL   = BG_VAL_DEF
) (
    input  logic       pix_clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic       i_de,
    input  logic [1:0] i_mode,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_de
);

    localparam int            XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

    logic [XW-1:0] x_q, x_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    y_q, y_d;
    mode_e         mode_q;

    logic          pix_b, in_rng, r1, r2, ram_we;
    logic [1:0]    ram_rd;

    logic [2:0]    col0_p1, col1_p1, col2_p1;
    logic          b_p1, hs_p1, vs_p1, de_p1;
    logic [7:0]    data_p1;

    logic          res_p1;
    logic [7:0]    pix_d;
    logic [7:0]    pix_p2;
    logic          hs_p2, vs_p2, de_p2;

    // ---- stage 0: threshold, counters, line-buffer access ----
    assign pix_b  = i_de & (i_data < THRESH);
    assign in_rng = ~ovf_q;
    // Rows above the frame top read as zero; stale RAM contents never leak in.
    assign r1     = ram_rd[0] & (y_q != 2'd0) & in_rng;
    assign r2     = ram_rd[1] & y_q[1] & in_rng;
    assign ram_we = i_de & in_rng;

    morph_line_ram #(
        .DEPTH (H_ACTIVE),
        .WIDTH (2)
    ) u_line_ram (
        .clk     (pix_clk),
        .we_i    (ram_we),
        .addr_i  (x_q),
        .wdata_i ({r1, pix_b}),
        .rdata_o (ram_rd)
    );

    always_comb begin
        x_d   = x_q;
        ovf_d = ovf_q;
        if (!i_de) begin
            x_d   = '0;
            ovf_d = 1'b0;
        end else if (x_q == X_LAST) begin
            ovf_d = 1'b1;
        end else begin
            x_d = x_q + 1'b1;
        end
    end

    always_comb begin
        y_d = y_q;
        if (i_vs) begin
            y_d = 2'd0;
        end else if (de_p1 && !i_de && y_q != 2'd2) begin
            y_d = y_q + 2'd1;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            x_q    <= '0;
            ovf_q  <= 1'b0;
            y_q    <= 2'd0;
            mode_q <= MODE_BIN;
        end else begin
            x_q   <= x_d;
            ovf_q <= ovf_d;
            y_q   <= y_d;
            if (i_vs && !vs_p1) begin
                mode_q <= mode_e'(i_mode);
            end
        end
    end

    // ---- stage 1: column window shift and delay pipe ----
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            col0_p1 <= 3'b000;
            col1_p1 <= 3'b000;
            col2_p1 <= 3'b000;
            hs_p1   <= 1'b0;
            vs_p1   <= 1'b0;
            de_p1   <= 1'b0;
        end else begin
            hs_p1 <= i_hs;
            vs_p1 <= i_vs;
            de_p1 <= i_de;
            if (i_de) begin
                col2_p1 <= col1_p1;
                col1_p1 <= col0_p1;
                col0_p1 <= {r2, r1, pix_b};
            end else begin
                col0_p1 <= 3'b000;
                col1_p1 <= 3'b000;
                col2_p1 <= 3'b000;
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        b_p1    <= pix_b;
        data_p1 <= i_data;
    end

    // ---- stage 2: mode select and output register ----
    always_comb begin
        res_p1 = b_p1;
        case (mode_q)
            MODE_DIL: res_p1 = |{col2_p1, col1_p1, col0_p1};
            MODE_ERO: res_p1 = &{col2_p1, col1_p1, col0_p1};
            default:  res_p1 = b_p1;
        endcase
        pix_d = (mode_q == MODE_RAW) ? data_p1 : pix_map(res_p1, EDGE_VAL, BG_VAL);
        if (!de_p1) begin
            pix_d = 8'h00;
        end
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            pix_p2 <= 8'h00;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            de_p2  <= 1'b0;
        end else begin
            pix_p2 <= pix_d;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            de_p2  <= de_p1;
        end
    end

    assign o_r  = pix_p2;
    assign o_g  = pix_p2;
    assign o_b  = pix_p2;
    assign o_hs = hs_p2;
    assign o_vs = vs_p2;
    assign o_de = de_p2;

endmodule

// File: tb/tb_edge_morph_filter.sv
// Directed bench for edge_morph_filter: small frames with hand-derived
// per-pixel expectations, checked two cycles after each input.
module tb_edge_morph_filter;

    localparam int H = 16;

    localparam int T_POST  = 0;
    localparam int T_FLAT  = 1;
    localparam int T_DIL   = 2;
    localparam int T_ERO   = 3;
    localparam int T_SOLID = 4;
    localparam int T_RAMP  = 5;
    localparam int T_THR   = 6;
    localparam int T_LONG  = 7;
    localparam int T_MID   = 8;

    logic       pix_clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_hs, i_vs, i_de;
    logic [1:0] i_mode;
    logic [7:0] o_r, o_g, o_b;
    logic       o_hs, o_vs, o_de;

    int checks   = 0;
    int failures = 0;

    logic [7:0] prev_pix;
    logic       prev_de, prev_hs, prev_vs, prev_ok;
    string      prev_tag;
    int         cur_tid, cur_x, cur_y;

    always #5 pix_clk = ~pix_clk;

    edge_morph_filter #(.H_ACTIVE(H)) dut (
        .pix_clk (pix_clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_hs    (i_hs),
        .i_vs    (i_vs),
        .i_de    (i_de),
        .i_mode  (i_mode),
        .o_r     (o_r),
        .o_g     (o_g),
        .o_b     (o_b),
        .o_hs    (o_hs),
        .o_vs    (o_vs),
        .o_de    (o_de)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int tid, input int x, input int y);
        case (tid)
            T_DIL, T_ERO: return (x == 10 && y == 5) ? 8'h00 : 8'hFF;
            T_SOLID:      return 8'h00;
            T_RAMP:       return 8'(x * 16 + y);
            T_THR: begin
                if (x == 0)          return 8'd0;
                else if (x == H - 1) return 8'd255;
                else if (x % 2 == 1) return 8'd200;
                else                 return 8'd199;
            end
            T_POST:       return (x == 3 && y == 0) ? 8'h00 : 8'hFF;
            T_LONG:       return (y == 0 && x >= H) ? 8'h00 : 8'hFF;
            default:      return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] expv(input int tid, input int x, input int y);
        case (tid)
            T_DIL:   return (x >= 10 && x <= 12 && y >= 5 && y <= 7) ? 8'h00 : 8'hFF;
            T_SOLID: return (x < 2 || y < 2) ? 8'hFF : 8'h00;
            T_RAMP:  return 8'(x * 16 + y);
            T_THR:   return (dat(tid, x, y) < 8'd200) ? 8'h00 : 8'hFF;
            T_POST:  return (x == 3 && y == 0) ? 8'h00 : 8'hFF;
            T_LONG:  return (y == 0 && x >= H) ? 8'h00 : 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    // Drive one cycle; outputs now reflect the inputs of the previous call.
    task automatic px(input logic [7:0] d, input logic de, input logic vs,
                      input logic hs, input logic [7:0] e);
        i_data = d;
        i_de   = de;
        i_vs   = vs;
        i_hs   = hs;
        @(posedge pix_clk);
        #1;
        if (prev_ok) begin
            chk({prev_tag, " r"},  o_r,  prev_pix);
            chk({prev_tag, " g"},  o_g,  prev_pix);
            chk({prev_tag, " b"},  o_b,  prev_pix);
            chk({prev_tag, " de"}, o_de, prev_de);
            chk({prev_tag, " hs"}, o_hs, prev_hs);
            chk({prev_tag, " vs"}, o_vs, prev_vs);
        end
        prev_pix = de ? e : 8'h00;
        prev_de  = de;
        prev_hs  = hs;
        prev_vs  = vs;
        prev_ok  = 1'b1;
        prev_tag = $sformatf("t%0d x%0d y%0d", cur_tid, cur_x, cur_y);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        i_data = 8'h00;
        i_de   = 1'b0;
        i_vs   = 1'b0;
        i_hs   = 1'b0;
        @(posedge pix_clk);
        #1;
        chk("rst r",  o_r,  8'h00);
        chk("rst g",  o_g,  8'h00);
        chk("rst b",  o_b,  8'h00);
        chk("rst de", o_de, 1'b0);
        chk("rst hs", o_hs, 1'b0);
        chk("rst vs", o_vs, 1'b0);
        rst      = 1'b0;
        prev_pix = 8'h00;
        prev_de  = 1'b0;
        prev_hs  = 1'b0;
        prev_vs  = 1'b0;
        prev_ok  = 1'b1;
        prev_tag = "post-rst";
    endtask

    task automatic run(input int tid, input logic [1:0] m, input logic [1:0] m_mid,
                       input bit do_vs, input int nrows, input int long_len);
        int len;
        cur_tid = tid;
        cur_x   = -1;
        cur_y   = -1;
        i_mode  = m;
        px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        if (do_vs) begin
            px(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            px(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        for (int y = 0; y < nrows; y++) begin
            len = (y == 0 && long_len > 0) ? long_len : H;
            if (y == 3) i_mode = m_mid;
            for (int x = 0; x < len; x++) begin
                cur_x = x;
                cur_y = y;
                px(dat(tid, x, y), 1'b1, 1'b0, 1'b0, expv(tid, x, y));
            end
            cur_x = -1;
            px(8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
            px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
            px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        rst     = 1'b0;
        i_data  = 8'h00;
        i_hs    = 1'b0;
        i_vs    = 1'b0;
        i_de    = 1'b0;
        i_mode  = 2'd0;
        prev_ok = 1'b0;
        prev_tag = "";
        cur_tid = -1;
        cur_x   = -1;
        cur_y   = -1;

        do_reset();
        // No vsync yet: binary mode still in force even though i_mode=1.
        run(T_POST,  2'd1, 2'd1, 1'b0, 2, 0);
        run(T_FLAT,  2'd1, 2'd1, 1'b1, 3, 0);
        run(T_DIL,   2'd1, 2'd1, 1'b1, 9, 0);
        run(T_ERO,   2'd2, 2'd2, 1'b1, 9, 0);
        run(T_SOLID, 2'd2, 2'd2, 1'b1, 5, 0);
        run(T_RAMP,  2'd3, 2'd3, 1'b1, 3, 0);
        run(T_THR,   2'd0, 2'd0, 1'b1, 2, 0);
        // Mode switched to erode mid-frame: dilate must persist to frame end.
        run(T_DIL,   2'd1, 2'd2, 1'b1, 9, 0);
        run(T_ERO,   2'd2, 2'd2, 1'b1, 9, 0);

        cur_tid = T_MID;
        for (int x = 0; x < 5; x++) begin
            cur_x = x;
            cur_y = 0;
            px(8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF);
        end
        do_reset();
        run(T_LONG,  2'd1, 2'd1, 1'b1, 3, H + 6);
        run(T_SOLID, 2'd2, 2'd2, 1'b1, 4, 0);
        px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        px(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_morph_filter.md
Name: edge_morph_filter

Overview:
- Post-processing stage directly downstream of the Sobel stage.
- Consumes the 8-bit Sobel grey output (white background, dark edges) and thresholds it to a binary edge map.
- Applies a selectable 3x3 morphological operation (dilate/erode) using two 1-bit line buffers.
- Drives RGB + hs/vs/de to the display path with a fixed 2-cycle latency.

Parameters:
- H_ACTIVE, 1280, active pixels per line; sets line-buffer depth and column counter range.
- THRESH, 8'd200, input pixel is an edge when i_data < THRESH.
- EDGE_VAL, 8'h00, output value for an edge pixel.
- BG_VAL, 8'hFF, output value for a background pixel.

Ports:
- pix_clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- i_data  in  8  Sobel grey pixel.
- i_hs  in  1  hsync.
- i_vs  in  1  vsync, active high.
- i_de  in  1  data enable.
- i_mode  in  2  0=binary, 1=dilate, 2=erode, 3=raw pass-through.
- o_r  out  8  result pixel.
- o_g  out  8  result pixel, same value as o_r.
- o_b  out  8  result pixel, same value as o_r.
- o_hs  out  1  hsync delayed 2 cycles.
- o_vs  out  1  vsync delayed 2 cycles.
- o_de  out  1  de delayed 2 cycles.

Behaviour:
- Clocking/reset: one clock, pix_clk. rst is synchronous and active high.
- Reset values: all outputs 0; col/row counters 0; window regs 0; mode_q 0.
- Line RAM contents are not reset; masking by the row counter makes them irrelevant.
- Edge bit: b = i_de & (i_data < THRESH), unsigned compare.
- Column counter x: cleared whenever i_de=0; increments per i_de=1 cycle; saturates at H_ACTIVE-1.
  - Pixels beyond H_ACTIVE-1 are processed with line-RAM reads forced to 0 and no writes.
- Row counter y:
  - Cleared while i_vs=1.
  - Increments on each i_de falling edge.
  - Saturates at 2; only y>=1 and y>=2 are distinguished.
- Line RAM: H_ACTIVE x 2 bits, addressed by x, read-before-write in the same cycle.
  - Read {r2,r1}, masked: r1 forced 0 when y<1, r2 forced 0 when y<2.
  - Write {r1,b} at x when i_de=1 and x is in range.
- Stage 1 (t+1):
  - On i_de=1, shift the column window: col2<=col1, col1<=col0, col0<={r2,r1,b}.
  - On i_de=0, clear all three columns, so x<2 sees zero padding.
  - Also register b and i_data into the delay pipe.
- Stage 2 (t+2): result selected by mode_q.
  - Binary: b delayed 2.
  - Dilate: OR of the 9 window bits.
  - Erode: AND of the 9 window bits. Zero padding forces 0 for x<2 and y<2.
  - Raw: o_r/g/b = i_data delayed 2.
- Output value: edge result -> EDGE_VAL, else BG_VAL. When o_de=0, o_r/g/b = 0.
- Window geometry: output at input pixel (x,y) covers rows y-2..y and cols x-2..x (not re-centred). Downstream accepts the 1-pixel/1-line shift.
- Latency: exactly 2 cycles for data and for hs/vs/de in all modes.
- Mode sampling: i_mode is captured into mode_q on the rising edge of i_vs only; mid-frame changes are ignored until the next frame.
- Boundary cases:
  - i_vs asserted mid-line: counters clear immediately; the pipe still drains 2 cycles.
  - Reset mid-frame: outputs 0 next cycle. The first frame after reset uses mode 0 until an i_vs rising edge.
  - i_de toggling inside a line (gaps): each gap restarts x and clears the window; the row counter increments on every de falling edge.

Decomposition:
- Shared package:
  - Mode encodings MODE_BIN/MODE_DIL/MODE_ERO/MODE_RAW.
  - Default EDGE_VAL/BG_VAL.
  - H_ACTIVE default, shared with the Sobel stage.
- One sub-module: morph_line_ram.
  - Single-port, read-before-write, 1-cycle-combinational-read style, parameterised depth and width.
  - Maps to distributed/block RAM.

Test Plan:
- Flat frame, i_data=255 for all pixels, mode 1 -> all active outputs 8'hFF; o_de matches i_de delayed 2 exactly.
- Single pixel i_data=0 at (x=10,y=5), rest 255, mode 1 -> 3x3 block of 8'h00 at x=10..12, y=5..7; all else 8'hFF.
- Same stimulus, mode 2 -> entire frame 8'hFF.
  - Solid-0 frame, mode 2 -> 8'hFF for x<2 or y<2, 8'h00 elsewhere.
- Mode 3 with ramp i_data=x[7:0] -> o_r=o_g=o_b=ramp delayed 2. Mode 0 with THRESH=200: 199 -> 8'h00, 200 -> 8'hFF.
- i_mode changed 1->2 mid-frame -> output stays dilate until the next i_vs rising edge, then erode.
- rst asserted mid-line, then a line longer than H_ACTIVE -> outputs 0 the cycle after rst; no line-RAM corruption, no X; the first two rows of the next frame behave as y<2 padding.
